// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: instruction field layout,
// opcode class ranges and ctrl_o bit positions.
package id_pkg;

   localparam int W_OPC_FIELD = 7;
   localparam int W_IMM       = 16;
   localparam int W_CTRL      = 6;

   // instruction field positions (32-bit instruction)
   localparam int OPC_LO   = 25;
   localparam int IMMF_BIT = 24;
   localparam int RD_LO    = 20;
   localparam int RS_LO    = 16;
   localparam int IMM_LO   = 0;

   // ctrl_o one-hot bit indices, ordered {inte,logic,shift,ld,st,br}
   localparam int C_INTE  = 5;
   localparam int C_LOGIC = 4;
   localparam int C_SHIFT = 3;
   localparam int C_LD    = 2;
   localparam int C_ST    = 1;
   localparam int C_BR    = 0;

   // opcode class ranges (inclusive)
   localparam logic [W_OPC_FIELD-1:0] OPC_INTE_LO   = 7'h00;
   localparam logic [W_OPC_FIELD-1:0] OPC_INTE_HI   = 7'h07;
   localparam logic [W_OPC_FIELD-1:0] OPC_SHIFT0_LO = 7'h08;
   localparam logic [W_OPC_FIELD-1:0] OPC_SHIFT0_HI = 7'h0A;
   localparam logic [W_OPC_FIELD-1:0] OPC_SHIFT1_LO = 7'h0C;
   localparam logic [W_OPC_FIELD-1:0] OPC_SHIFT1_HI = 7'h0D;
   localparam logic [W_OPC_FIELD-1:0] OPC_LOGIC_LO  = 7'h10;
   localparam logic [W_OPC_FIELD-1:0] OPC_LOGIC_HI  = 7'h13;
   localparam logic [W_OPC_FIELD-1:0] OPC_SET_LO    = 7'h16;
   localparam logic [W_OPC_FIELD-1:0] OPC_SET_HI    = 7'h17;
   localparam logic [W_OPC_FIELD-1:0] OPC_LD        = 7'h18;
   localparam logic [W_OPC_FIELD-1:0] OPC_ST        = 7'h19;
   localparam logic [W_OPC_FIELD-1:0] OPC_BR_LO     = 7'h1C;
   localparam logic [W_OPC_FIELD-1:0] OPC_BR_HI     = 7'h1F;

   typedef enum logic [2:0] {
      CL_INTE,
      CL_LOGIC,
      CL_SHIFT,
      CL_SET,
      CL_LD,
      CL_ST,
      CL_BR,
      CL_UND
   } iclass_t;

   function automatic iclass_t classify(input logic [W_OPC_FIELD-1:0] opc);
      iclass_t cls;
      case (opc) inside
         [OPC_INTE_LO:OPC_INTE_HI]:     cls = CL_INTE;
         [OPC_SHIFT0_LO:OPC_SHIFT0_HI]: cls = CL_SHIFT;
         [OPC_SHIFT1_LO:OPC_SHIFT1_HI]: cls = CL_SHIFT;
         [OPC_LOGIC_LO:OPC_LOGIC_HI]:   cls = CL_LOGIC;
         [OPC_SET_LO:OPC_SET_HI]:       cls = CL_SET;
         OPC_LD:                        cls = CL_LD;
         OPC_ST:                        cls = CL_ST;
         [OPC_BR_LO:OPC_BR_HI]:         cls = CL_BR;
         default:                       cls = CL_UND;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/g_register_p.sv
// Register file: two combinational read ports, one write port, and a
// same-cycle write bypass so a reader sees the value being written back.
module g_register_p #(
   parameter int N_REG   = 16,
   parameter int W_DATA  = 32,
   parameter int W_RADDR = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wen,
   input  logic [W_RADDR-1:0] waddr,
   input  logic [W_DATA-1:0]  wdata,
   input  logic [W_RADDR-1:0] raddr_a,
   output logic [W_DATA-1:0]  rdata_a,
   input  logic [W_RADDR-1:0] raddr_b,
   output logic [W_DATA-1:0]  rdata_b
);

   logic [W_DATA-1:0] regs [N_REG];

   // storage: cleared on reset, written by write-back
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REG; i++) regs[i] <= '0;
      end else if (wen) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (wen && (waddr == raddr_a)) ? wdata : regs[raddr_a];
   assign rdata_b = (wen && (waddr == raddr_b)) ? wdata : regs[raddr_b];

endmodule

// File: rtl/id_stage_p.sv
// Decode stage: decodes one instruction per cycle behind valid/ready
// handshakes, reads rd/rs from the register file, extends the immediate and
// tracks pending writes per register to stall RAW/WAW hazards.
module id_stage_p
   import id_pkg::*;
#(
   parameter int W_DATA  = 32,
   parameter int N_REG   = 16,
   parameter int W_RADDR = 4,
   parameter int W_INST  = 32,
   parameter int W_OPC   = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [W_INST-1:0]  inst_i,
   input  logic               flush_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [5:0]         ctrl_o,
   output logic               wen_o,
   output logic [W_RADDR-1:0] rd_addr_o,
   output logic [W_DATA-1:0]  rd_value_o,
   output logic [W_DATA-1:0]  rs_value_o,
   output logic [W_DATA-1:0]  imm_value_o,
   output logic               immf_o,
   output logic               und_o,
   input  logic               wb_i,
   input  logic [W_RADDR-1:0] wb_r_i,
   input  logic [W_DATA-1:0]  wb_data_i
);

   logic [W_OPC-1:0]   opc;
   logic               immf;
   logic [W_RADDR-1:0] rd;
   logic [W_RADDR-1:0] rs;
   logic [W_IMM-1:0]   imm;

   assign opc  = inst_i[OPC_LO +: W_OPC];
   assign immf = inst_i[IMMF_BIT];
   assign rd   = inst_i[RD_LO +: W_RADDR];
   assign rs   = inst_i[RS_LO +: W_RADDR];
   assign imm  = inst_i[IMM_LO +: W_IMM];

   iclass_t           cls;
   logic [W_CTRL-1:0] ctrl_d;
   logic              wen_d;
   logic              und_d;
   logic [W_DATA-1:0] imm_d;

   assign cls = classify(opc);

   // class decode: one-hot control, write enable and immediate extension
   always_comb begin
      ctrl_d = '0;
      wen_d  = 1'b0;
      und_d  = 1'b0;
      imm_d  = W_DATA'(signed'(imm));
      case (cls)
         CL_INTE:  begin ctrl_d[C_INTE]  = 1'b1; wen_d = 1'b1; end
         CL_LOGIC: begin ctrl_d[C_LOGIC] = 1'b1; wen_d = 1'b1; imm_d = W_DATA'(imm); end
         CL_SHIFT: begin ctrl_d[C_SHIFT] = 1'b1; wen_d = 1'b1; imm_d = W_DATA'(imm); end
         CL_SET:   wen_d = 1'b1;
         CL_LD:    begin ctrl_d[C_LD]    = 1'b1; wen_d = 1'b1; end
         CL_ST:    ctrl_d[C_ST] = 1'b1;
         CL_BR:    ctrl_d[C_BR] = 1'b1;
         default:  und_d = 1'b1;
      endcase
   end

   logic [W_DATA-1:0] rd_rdata;
   logic [W_DATA-1:0] rs_rdata;

   g_register_p #(
      .N_REG   (N_REG),
      .W_DATA  (W_DATA),
      .W_RADDR (W_RADDR)
   ) u_regs (
      .clk     (clk),
      .rst     (rst),
      .wen     (wb_i),
      .waddr   (wb_r_i),
      .wdata   (wb_data_i),
      .raddr_a (rd),
      .rdata_a (rd_rdata),
      .raddr_b (rs),
      .rdata_b (rs_rdata)
   );

   logic [N_REG-1:0] pending;
   logic [N_REG-1:0] wb_mask;
   logic [N_REG-1:0] pend_eff;
   logic [N_REG-1:0] pend_nxt;
   logic             hazard;
   logic             accept;
   logic             load;

   // write-back mask; a register being written back this cycle is no longer pending
   always_comb begin
      wb_mask = '0;
      if (wb_i) wb_mask[wb_r_i] = 1'b1;
   end

   assign pend_eff   = pending & ~wb_mask;
   assign hazard     = pend_eff[rd] | (pend_eff[rs] & ~immf);
   assign in_ready_o = ~flush_i & ~hazard & (~out_valid_o | out_ready_i);
   assign accept     = in_valid_i & in_ready_o;
   assign load       = accept & ~und_d;

   // scoreboard next state: a same-edge set overrides a write-back clear
   always_comb begin
      pend_nxt = pend_eff;
      if (flush_i && out_valid_o && wen_o) pend_nxt[rd_addr_o] = 1'b0;
      if (load && wen_d) pend_nxt[rd] = 1'b1;
   end

   // scoreboard register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pending <= '0;
      else      pending <= pend_nxt;
   end

   // output register: flush beats load, load beats bubble, otherwise hold.
   // An undefined opcode loads nothing, so the entry still drains if EX takes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o <= 1'b0;
         ctrl_o      <= '0;
         wen_o       <= 1'b0;
         rd_addr_o   <= '0;
         rd_value_o  <= '0;
         rs_value_o  <= '0;
         imm_value_o <= '0;
         immf_o      <= 1'b0;
         und_o       <= 1'b0;
      end else begin
         und_o <= accept & und_d;
         if (flush_i) begin
            out_valid_o <= 1'b0;
            ctrl_o      <= '0;
            wen_o       <= 1'b0;
         end else if (load) begin
            out_valid_o <= 1'b1;
            ctrl_o      <= ctrl_d;
            wen_o       <= wen_d;
            rd_addr_o   <= rd;
            rd_value_o  <= rd_rdata;
            rs_value_o  <= rs_rdata;
            imm_value_o <= imm_d;
            immf_o      <= immf;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
            ctrl_o      <= '0;
            wen_o       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: accepted instructions push their expected
// decode onto a queue, and entries are compared when presented on the output.
module tb_id_stage_p;

   logic        clk;
   logic        rst;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] inst_i;
   logic        flush_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [5:0]  ctrl_o;
   logic        wen_o;
   logic [3:0]  rd_addr_o;
   logic [31:0] rd_value_o;
   logic [31:0] rs_value_o;
   logic [31:0] imm_value_o;
   logic        immf_o;
   logic        und_o;
   logic        wb_i;
   logic [3:0]  wb_r_i;
   logic [31:0] wb_data_i;

   id_stage_p dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .inst_i      (inst_i),
      .flush_i     (flush_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .ctrl_o      (ctrl_o),
      .wen_o       (wen_o),
      .rd_addr_o   (rd_addr_o),
      .rd_value_o  (rd_value_o),
      .rs_value_o  (rs_value_o),
      .imm_value_o (imm_value_o),
      .immf_o      (immf_o),
      .und_o       (und_o),
      .wb_i        (wb_i),
      .wb_r_i      (wb_r_i),
      .wb_data_i   (wb_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  ctrl;
      logic        wen;
      logic [3:0]  rd;
      logic [31:0] rdv;
      logic [31:0] rsv;
      logic [31:0] imm;
      logic        immf;
   } exp_t;

   exp_t        q[$];
   logic [31:0] rf_m [16];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic immf,
                                           input logic [3:0] rd, input logic [3:0] rs,
                                           input logic [15:0] imm);
      return {opc, immf, rd, rs, imm};
   endfunction

   function automatic logic [31:0] rd_model(input logic [3:0] r);
      return (wb_i && wb_r_i == r) ? wb_data_i : rf_m[r];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock; mirror write-back into the model register file
   task automatic tick();
      logic        we;
      logic [3:0]  r;
      logic [31:0] d;
      we = wb_i; r = wb_r_i; d = wb_data_i;
      @(posedge clk);
      if (we && rst) rf_m[r] = d;
      #1;
   endtask

   // present an instruction expected to be accepted and record its decode
   task automatic send(input logic [6:0] opc, input logic immf, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [15:0] imm,
                       input logic [5:0] ctrl, input logic wen, input logic zext);
      exp_t e;
      inst_i     = mk_inst(opc, immf, rd, rs, imm);
      in_valid_i = 1'b1;
      #1;
      chk("in_ready", {31'd0, in_ready_o}, 32'd1);
      e.ctrl = ctrl;
      e.wen  = wen;
      e.rd   = rd;
      e.rdv  = rd_model(rd);
      e.rsv  = rd_model(rs);
      e.imm  = zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
      e.immf = immf;
      q.push_back(e);
   endtask

   task automatic check_out(input string tag, input bit pop);
      exp_t e;
      chk({tag, "_qsize"}, (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() > 0) begin
         e = q[0];
         chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
         chk({tag, "_ctrl"},  {26'd0, ctrl_o}, {26'd0, e.ctrl});
         chk({tag, "_wen"},   {31'd0, wen_o}, {31'd0, e.wen});
         chk({tag, "_rd"},    {28'd0, rd_addr_o}, {28'd0, e.rd});
         chk({tag, "_rdv"},   rd_value_o, e.rdv);
         chk({tag, "_rsv"},   rs_value_o, e.rsv);
         chk({tag, "_imm"},   imm_value_o, e.imm);
         chk({tag, "_immf"},  {31'd0, immf_o}, {31'd0, e.immf});
         if (pop) void'(q.pop_front());
      end
   endtask

   initial begin
      rst = 1'b0; in_valid_i = 1'b0; inst_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
      wb_i = 1'b0; wb_r_i = '0; wb_data_i = '0;
      foreach (rf_m[i]) rf_m[i] = '0;
      tick(); tick();
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_ctrl",  {26'd0, ctrl_o}, 32'd0);
      chk("rst_wen",   {31'd0, wen_o}, 32'd0);
      chk("rst_rd",    {28'd0, rd_addr_o}, 32'd0);
      chk("rst_rdv",   rd_value_o, 32'd0);
      chk("rst_rsv",   rs_value_o, 32'd0);
      chk("rst_imm",   imm_value_o, 32'd0);
      chk("rst_immf",  {31'd0, immf_o}, 32'd0);
      chk("rst_und",   {31'd0, und_o}, 32'd0);
      rst = 1'b1;
      tick();

      // r5 = 0x1234, then inte rd=3 rs=5
      wb_i = 1'b1; wb_r_i = 4'd5; wb_data_i = 32'h1234;
      tick();
      wb_i = 1'b0;
      send(7'h00, 1'b0, 4'd3, 4'd5, 16'h0010, 6'b100000, 1'b1, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("inte", 1'b1);

      // r3 pending blocks a reader; same-cycle write-back releases and bypasses
      inst_i = mk_inst(7'h10, 1'b0, 4'd1, 4'd3, 16'h8001); in_valid_i = 1'b1;
      #1;
      chk("raw_r3", {31'd0, in_ready_o}, 32'd0);
      tick();
      chk("bubble_valid", {31'd0, out_valid_o}, 32'd0);
      wb_i = 1'b1; wb_r_i = 4'd3; wb_data_i = 32'h3333;
      send(7'h10, 1'b0, 4'd1, 4'd3, 16'h8001, 6'b010000, 1'b1, 1'b1);
      tick(); wb_i = 1'b0; in_valid_i = 1'b0;
      check_out("logic_bypass", 1'b1);

      // ld r2 followed by a reader of r2
      send(7'h18, 1'b1, 4'd2, 4'd0, 16'h0004, 6'b000100, 1'b1, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("ld", 1'b1);
      inst_i = mk_inst(7'h00, 1'b0, 4'd4, 4'd2, 16'h8001); in_valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("raw_r2", {31'd0, in_ready_o}, 32'd0);
         tick();
      end
      chk("drained_valid", {31'd0, out_valid_o}, 32'd0);
      wb_i = 1'b1; wb_r_i = 4'd2; wb_data_i = 32'hCAFE;
      send(7'h00, 1'b0, 4'd4, 4'd2, 16'h8001, 6'b100000, 1'b1, 1'b0);
      tick(); wb_i = 1'b0; in_valid_i = 1'b0;
      check_out("inte_cafe", 1'b1);
      tick();
      chk("drain2_valid", {31'd0, out_valid_o}, 32'd0);

      // undefined opcode 0x0B
      inst_i = mk_inst(7'h0B, 1'b0, 4'd9, 4'd9, 16'h0000); in_valid_i = 1'b1;
      #1;
      chk("und_ready", {31'd0, in_ready_o}, 32'd1);
      tick(); in_valid_i = 1'b0;
      chk("und_pulse", {31'd0, und_o}, 32'd1);
      chk("und_valid", {31'd0, out_valid_o}, 32'd0);
      tick();
      chk("und_end", {31'd0, und_o}, 32'd0);
      chk("und_valid2", {31'd0, out_valid_o}, 32'd0);

      // set-class writing r9 (not left pending by the undefined opcode)
      send(7'h16, 1'b1, 4'd9, 4'd0, 16'hFFFF, 6'b000000, 1'b1, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("set", 1'b0);

      // back-pressure for 3 cycles
      out_ready_i = 1'b0;
      inst_i = mk_inst(7'h19, 1'b0, 4'd5, 4'd6, 16'h00FF); in_valid_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", {31'd0, in_ready_o}, 32'd0);
         tick();
         check_out("hold", 1'b0);
      end
      out_ready_i = 1'b1; in_valid_i = 1'b0;
      #1;
      check_out("set_drain", 1'b1);
      tick();
      chk("bp_bubble", {31'd0, out_valid_o}, 32'd0);

      // store and branch
      send(7'h19, 1'b0, 4'd5, 4'd6, 16'h00FF, 6'b000010, 1'b0, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("st", 1'b1);
      send(7'h1C, 1'b0, 4'd10, 4'd11, 16'h8000, 6'b000001, 1'b0, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("br", 1'b1);

      // shift writing r7, then flushed while stalled
      send(7'h0D, 1'b1, 4'd7, 4'd5, 16'h8001, 6'b001000, 1'b1, 1'b1);
      tick(); in_valid_i = 1'b0;
      check_out("shift", 1'b0);
      out_ready_i = 1'b0; flush_i = 1'b1;
      inst_i = mk_inst(7'h00, 1'b1, 4'd8, 4'd0, 16'h0000); in_valid_i = 1'b1;
      #1;
      chk("flush_ready", {31'd0, in_ready_o}, 32'd0);
      tick(); flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      void'(q.pop_front());
      chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
      send(7'h01, 1'b0, 4'd7, 4'd7, 16'h0001, 6'b100000, 1'b1, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("after_flush", 1'b1);

      // reset mid-operation discards output, scoreboard and register file
      rst = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("midrst_ctrl",  {26'd0, ctrl_o}, 32'd0);
      foreach (rf_m[i]) rf_m[i] = '0;
      rst = 1'b1;
      send(7'h00, 1'b0, 4'd1, 4'd5, 16'h0000, 6'b100000, 1'b1, 1'b0);
      tick(); in_valid_i = 1'b0;
      check_out("post_rst", 1'b1);

      chk("q_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
